// File: rtl/ftou_pkg.sv
// Shared types and helpers for the float-to-unsigned converter pipeline.
package ftou_pkg;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/ftou_shift_round.sv
// S2/S3 datapath: aligns {1, mantissa} to the binary point, then truncates or rounds and saturates.
// FTOU_ROUND_NEAREST_EN selects round-to-nearest-even in S3; otherwise truncation toward zero.
module ftou_shift_round
    import ftou_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int INT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sign,
    input  logic [1:0]       cls,
    input  logic [EXP_W:0]   e,
    input  logic [MAN_W-1:0] man,
    output logic [INT_W-1:0] res,
    output logic             overflow,
    output logic             invalid
);

    localparam int SW  = INT_W + MAN_W + 1;
    localparam int SHW = $clog2(INT_W);

    logic signed [31:0] e_i;
    logic [SW-1:0]      wide;
    logic [INT_W-1:0]   int_d, int_q, res_d;
    logic               ovf_d, ovf_q, inv_d, inv_q, ovf3_d;

    assign e_i = 32'($signed(e));
    // Binary point sits at bit MAN_W of wide; only meaningful for 0 <= e < INT_W.
    assign wide = SW'({1'b1, man}) << e[SHW-1:0];

`ifdef FTOU_ROUND_NEAREST_EN
    logic             g_d, s_d, g_q, s_q, rnd_up;
    logic [INT_W:0]   sum;
`endif

    always_comb begin
        int_d = '0;
        ovf_d = 1'b0;
        inv_d = 1'b0;
`ifdef FTOU_ROUND_NEAREST_EN
        g_d   = 1'b0;
        s_d   = 1'b0;
`endif
        case (cls_e'(cls))
            CLS_NAN: inv_d = 1'b1;
            CLS_INF: begin
                if (sign) inv_d = 1'b1;
                else      ovf_d = 1'b1;
            end
            CLS_NORM: begin
                if (e_i < 0) begin
`ifdef FTOU_ROUND_NEAREST_EN
                    // Positive fractions only; negatives below one stay 0.
                    if (!sign) begin
                        g_d = (e_i == -1);
                        s_d = (e_i == -1) ? |man : 1'b1;
                    end
`endif
                end else if (sign) begin
                    inv_d = 1'b1;
                end else if (e_i >= INT_W) begin
                    ovf_d = 1'b1;
                end else begin
                    int_d = INT_W'(wide >> MAN_W);
`ifdef FTOU_ROUND_NEAREST_EN
                    g_d   = wide[MAN_W-1];
                    s_d   = |wide[MAN_W-2:0];
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= '0;
            ovf_q <= 1'b0;
            inv_q <= 1'b0;
`ifdef FTOU_ROUND_NEAREST_EN
            g_q   <= 1'b0;
            s_q   <= 1'b0;
`endif
        end else if (en) begin
            int_q <= int_d;
            ovf_q <= ovf_d;
            inv_q <= inv_d;
`ifdef FTOU_ROUND_NEAREST_EN
            g_q   <= g_d;
            s_q   <= s_d;
`endif
        end
    end

`ifdef FTOU_ROUND_NEAREST_EN
    assign rnd_up = g_q & (s_q | int_q[0]);
    assign sum    = {1'b0, int_q} + {{INT_W{1'b0}}, rnd_up};
    assign ovf3_d = ovf_q | sum[INT_W];
    assign res_d  = ovf3_d ? '1 : sum[INT_W-1:0];
`else
    assign ovf3_d = ovf_q;
    assign res_d  = ovf_q ? '1 : int_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res      <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else if (en) begin
            res      <= res_d;
            overflow <= ovf3_d;
            invalid  <= inv_q;
        end
    end

endmodule

// File: rtl/float_to_uint_pipe.sv
// Three-stage IEEE-754 float to unsigned integer converter with valid/ready backpressure.
// Define FTOU_ROUND_NEAREST_EN for round-to-nearest-even instead of truncation.
module float_to_uint_pipe
    import ftou_pkg::*;
#(
    parameter int EXP_W = 11,
    parameter int MAN_W = 52,
    parameter int INT_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [EXP_W+MAN_W:0]   in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [INT_W-1:0]       out_data,
    output logic                   out_overflow,
    output logic                   out_invalid,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int             EW     = EXP_W + 1;
    localparam logic [EW-1:0]  BIAS_E = EW'(bias(EXP_W));

    typedef struct packed {
        logic             sign;
        cls_e             cls;
        logic [EW-1:0]    e;
        logic [MAN_W-1:0] man;
    } s1_t;

    s1_t              s1_d, s1_q;
    logic [EXP_W-1:0] exp_f;
    logic             v1_q, v2_q, advance;

    // Whole pipe moves together; out_ready reaches in_ready combinationally.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign exp_f = in_data[EXP_W+MAN_W-1 -: EXP_W];

    always_comb begin
        s1_d.sign = in_data[EXP_W+MAN_W];
        s1_d.man  = in_data[MAN_W-1:0];
        s1_d.e    = {1'b0, exp_f} - BIAS_E;
        if (exp_f == '0)
            s1_d.cls = CLS_ZERO;
        else if (&exp_f)
            s1_d.cls = (in_data[MAN_W-1:0] == '0) ? CLS_INF : CLS_NAN;
        else
            s1_d.cls = CLS_NORM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            s1_q      <= s1_d;
            v1_q      <= in_valid;
            v2_q      <= v1_q;
            out_valid <= v2_q;
        end
    end

    ftou_shift_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W),
        .INT_W (INT_W)
    ) u_shift_round (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .sign     (s1_q.sign),
        .cls      (s1_q.cls),
        .e        (s1_q.e),
        .man      (s1_q.man),
        .res      (out_data),
        .overflow (out_overflow),
        .invalid  (out_invalid)
    );

endmodule

// File: tb/tb_float_to_uint_pipe.sv
// Scoreboard bench for float_to_uint_pipe (binary64 main instance, binary32 side instance).
module tb_float_to_uint_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_overflow, out_invalid, out_valid;
    logic        out_ready = 1'b1;

    logic [31:0] in32 = '0;
    logic        in32_valid = 1'b0;
    logic        in32_ready;
    logic [31:0] out32;
    logic        out32_ovf, out32_inv, out32_valid;

    always #5 clk = ~clk;

    float_to_uint_pipe #(.EXP_W(11), .MAN_W(52), .INT_W(64)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_overflow(out_overflow), .out_invalid(out_invalid),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    float_to_uint_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_data(in32), .in_valid(in32_valid), .in_ready(in32_ready),
        .out_data(out32), .out_overflow(out32_ovf), .out_invalid(out32_inv),
        .out_valid(out32_valid), .out_ready(1'b1)
    );

    typedef struct {
        logic [63:0] d;
        logic        ovf;
        logic        inv;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Value-level reference: x = 1.man * 2^e as a 64.64 fixed-point number.
    function automatic exp_t model(input logic [63:0] f);
        exp_t         r;
        logic [127:0] q;
        logic [63:0]  ip;
        int           ex, e;
`ifdef FTOU_ROUND_NEAREST_EN
        logic [63:0]  fr;
`endif
        r.d = '0; r.ovf = 1'b0; r.inv = 1'b0; r.acc = 0; r.lat = 1'b0;
        ex = int'(f[62:52]);
        if (ex == 2047) begin
            if (f[51:0] != 0 || f[63]) r.inv = 1'b1;
            else begin r.ovf = 1'b1; r.d = '1; end
        end else if (ex != 0) begin
            e = ex - 1023;
            if (f[63]) r.inv = (e >= 0);
            else if (e >= 64) begin r.ovf = 1'b1; r.d = '1; end
            else begin
                q = {11'd0, 1'b1, f[51:0], 64'd0};
                if (e >= 52) q = q << (e - 52);
                else if (52 - e >= 128) q = '0;
                else q = q >> (52 - e);
                ip = q[127:64];
`ifdef FTOU_ROUND_NEAREST_EN
                fr = q[63:0];
                if (fr > 64'h8000_0000_0000_0000 || (fr == 64'h8000_0000_0000_0000 && ip[0])) begin
                    if (&ip) begin r.ovf = 1'b1; r.d = '1; end
                    else r.d = ip + 64'd1;
                end else r.d = ip;
`else
                r.d = ip;
`endif
            end
        end
        return r;
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input logic o, input logic i);
        exp_t r;
        r.d = d; r.ovf = o; r.inv = i; r.acc = 0; r.lat = 1'b1;
        return r;
    endfunction

    // Offer one operand from the next falling edge until accepted; in_valid stays high afterwards.
    task automatic send(input logic [63:0] f, input exp_t ex);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = f;
        #1;
        n = 0;
        while (!in_ready) begin
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
                return;
            end
            @(negedge clk);
            #1;
            n++;
        end
        ex.acc = cyc;
        sbq.push_back(ex);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2;
        check("drain_queue_empty", 64'(sbq.size()), 64'd0);
    endtask

    always @(negedge clk) if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);

    // Monitor: pops on every output handshake and tracks when each result first appeared.
    initial begin
        bit   present;
        int   appear;
        exp_t e;
        present = 1'b0;
        appear  = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) present = 1'b0;
            else if (out_valid) begin
                if (!present) begin present = 1'b1; appear = cyc; end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_result: got %h with empty scoreboard, expected none", out_data);
                    end else begin
                        e = sbq.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_overflow", 64'(out_overflow), 64'(e.ovf));
                        check("out_invalid", 64'(out_invalid), 64'(e.inv));
                        if (e.lat) check("latency", 64'(appear - e.acc), 64'd3);
                    end
                    present = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

`ifdef FTOU_ROUND_NEAREST_EN
    localparam logic [63:0] R35 = 64'd4, R075 = 64'd1, R15 = 64'd2;
`else
    localparam logic [63:0] R35 = 64'd3, R075 = 64'd0, R15 = 64'd1;
`endif

    initial begin
        logic [63:0] bp_vals [5];
        logic [63:0] f;
        logic [10:0] ex;
        int          k;

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_flags", 64'({out_overflow, out_invalid}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'd1);

        // Directed values, out_ready held high so latency is checked
        send(64'h3FF0_0000_0000_0000, mk(64'd1, 0, 0));
        send(64'h4045_0000_0000_0000, mk(64'd42, 0, 0));
        send(64'h0000_0000_0000_0001, mk(64'd0, 0, 0));
        send(64'h4004_0000_0000_0000, mk(64'd2, 0, 0));
        send(64'h400C_0000_0000_0000, mk(R35, 0, 0));
        send(64'h3FE8_0000_0000_0000, mk(R075, 0, 0));
        send(64'h3FF8_0000_0000_0000, mk(R15, 0, 0));
        send(64'h3FE0_0000_0000_0000, mk(64'd0, 0, 0));
        send(64'h43F0_0000_0000_0000, mk('1, 1, 0));
        send(64'h7FF0_0000_0000_0000, mk('1, 1, 0));
        send(64'hFFF0_0000_0000_0000, mk(64'd0, 0, 1));
        send(64'hBFF0_0000_0000_0000, mk(64'd0, 0, 1));
        send(64'h7FF8_0000_0000_0000, mk(64'd0, 0, 1));
        send(64'hFFF0_0000_0000_0001, mk(64'd0, 0, 1));
        send(64'hBFE0_0000_0000_0000, mk(64'd0, 0, 0));
        send(64'hBFE6_6666_6666_6666, mk(64'd0, 0, 0));
        send(64'h8000_0000_0000_0000, mk(64'd0, 0, 0));
        send(64'h43E0_0000_0000_0000, mk(64'h8000_0000_0000_0000, 0, 0));
        send(64'h43EF_FFFF_FFFF_FFFF, mk(64'hFFFF_FFFF_FFFF_F800, 0, 0));
        idle();
        drain();

        // Backpressure: 1.0..5.0 back to back, out_ready low in relative cycles 4-8
        bp_vals[0] = 64'h3FF0_0000_0000_0000;
        bp_vals[1] = 64'h4000_0000_0000_0000;
        bp_vals[2] = 64'h4008_0000_0000_0000;
        bp_vals[3] = 64'h4010_0000_0000_0000;
        bp_vals[4] = 64'h4014_0000_0000_0000;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            out_ready = !(i >= 4 && i <= 8);
            if (k < 5) begin
                in_valid = 1'b1;
                in_data  = bp_vals[k];
            end else in_valid = 1'b0;
            #1;
            if (i >= 4 && i <= 8) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
                check("stall_out_data_held", out_data, 64'd1);
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = mk(64'(k + 1), 0, 0);
                e.lat = 1'b0;
                e.acc = cyc;
                sbq.push_back(e);
                k++;
            end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(k), 64'd5);
        drain();

        // Reset with two results in flight
        out_ready = 1'b0;
        send(64'h3FF0_0000_0000_0000, mk(64'd1, 0, 0));
        send(64'h4000_0000_0000_0000, mk(64'd2, 0, 0));
        idle();
        @(negedge clk);
        #3;
        check("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_out_valid", 64'(out_valid), 64'd0);
        check("async_reset_out_data", out_data, 64'd0);
        sbq.delete();
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(64'h401C_0000_0000_0000, mk(64'd7, 0, 0));
        idle();
        drain();

        // Randomised traffic with random backpressure
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       ex = 11'd0;
                1:       ex = 11'h7FF;
                2:       ex = 11'($urandom_range(0, 2046));
                default: ex = 11'($urandom_range(1015, 1090));
            endcase
            f = {1'($urandom_range(0, 1)), ex, 20'($urandom), $urandom};
            if ($urandom_range(0, 7) == 0) f[51:0] = 52'd0;
            else if ($urandom_range(0, 7) == 0) f[51:0] = {1'b1, 51'd0};
            send(f, model(f));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rand_rdy = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Binary32 side instance
        for (int j = 0; j < 3; j++) begin
            logic [31:0] v, exp_d;
            logic        exp_o;
            case (j)
                0: begin v = 32'h4F80_0000; exp_d = 32'hFFFF_FFFF; exp_o = 1'b1; end
                1: begin v = 32'h4F7F_FFFF; exp_d = 32'hFFFF_FF00; exp_o = 1'b0; end
                default: begin v = 32'h3F80_0000; exp_d = 32'd1; exp_o = 1'b0; end
            endcase
            @(negedge clk);
            in32 = v;
            in32_valid = 1'b1;
            @(negedge clk);
            in32_valid = 1'b0;
            @(negedge clk);
            @(negedge clk);
            #2;
            check("b32_valid", 64'(out32_valid), 64'd1);
            check("b32_data", 64'(out32), 64'(exp_d));
            check("b32_flags", 64'({out32_ovf, out32_inv}), 64'({exp_o, 1'b0}));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
